pwm_capture: RTL and testbench

Measures an incoming PWM waveform, such as the breathing-LED drive or any externally supplied duty-cycle signal, and reports its period and active-time in clock cycles. The input is synchronized, edge-detected and timed by free-running counters. Each completed period is published with a one-cycle valid strobe. A timeout flag flags a stuck line (0 % / 100 % duty or a dead source). The block sits between an asynchronous pin and control logic that needs the measured duty.

---
 rtl/pwm_capture.sv | 138 +++++++++++++
 tb/tb_pwm_capture.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and active time of an asynchronous PWM input
// in clock cycles, with a one-cycle valid strobe and a sticky stuck-line flag.
module pwm_capture #(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned MAX_CNT = 9600,
    parameter bit          INVERT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout,
    output logic             level
);

    localparam logic [CNT_W-1:0] PCNT_TOP = CNT_W'(MAX_CNT - 1);
    localparam logic [CNT_W-1:0] HCNT_TOP = CNT_W'(MAX_CNT);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             s1;
    logic             s2;
    logic             prev;
    logic             c;
    logic             c_prev;
    logic             rise;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic             valid_nxt;
    logic             latch;
    logic             to_set;

    // prev keeps the raw s2 and is conditioned alongside it, so the all-zero
    // reset state never reads as a rise even when the input is active-low.
    assign c      = s2 ^ INVERT;
    assign c_prev = prev ^ INVERT;
    assign rise   = c & ~c_prev;

    // Two-flop synchronizer plus previous-level register for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Period and active-time counters, restarted by each rise and saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            hcnt <= '0;
        end else begin
            if (rise) begin
                pcnt <= '0;
            end else if (pcnt != PCNT_TOP) begin
                pcnt <= pcnt + CNT_W'(1);
            end

            if (rise) begin
                hcnt <= CNT_W'(1);
            end else if (c && (hcnt != HCNT_TOP)) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and measurement/timeout decisions; a rise beats the threshold.
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        latch     = 1'b0;
        to_set    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else if ((pcnt == PCNT_TOP) && !timeout) begin
                    to_set = 1'b1;
                end
            end
            MEAS: begin
                if (rise) begin
                    latch     = 1'b1;
                    valid_nxt = 1'b1;
                end else if (pcnt == PCNT_TOP) begin
                    to_set    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs: measurement latch, strobe, sticky timeout and level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            level     <= 1'b0;
        end else begin
            valid <= valid_nxt;
            if (latch) begin
                period    <= pcnt + CNT_W'(1);
                high_time <= hcnt;
            end
            if (rise) begin
                timeout <= 1'b0;
            end else if (to_set) begin
                timeout <= 1'b1;
                level   <= s2;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: three pwm_capture instances (active-low, active-high, and
// a small 64-cycle threshold) checked every cycle against an edge-time model.
module tb_pwm_capture;

    localparam int NI = 3;
    localparam int CW = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n;
    logic [NI-1:0] pin;
    logic [CW-1:0] per [NI];
    logic [CW-1:0] hti [NI];
    logic [NI-1:0] val;
    logic [NI-1:0] tmo;
    logic [NI-1:0] lvl;

    pwm_capture #(.CNT_W(CW), .MAX_CNT(9600), .INVERT(1'b1)) u_inv (
        .clk(clk), .rst(rst_n[0]), .pwm_in(pin[0]), .period(per[0]),
        .high_time(hti[0]), .valid(val[0]), .timeout(tmo[0]), .level(lvl[0]));

    pwm_capture #(.CNT_W(CW), .MAX_CNT(9600), .INVERT(1'b0)) u_hi (
        .clk(clk), .rst(rst_n[1]), .pwm_in(pin[1]), .period(per[1]),
        .high_time(hti[1]), .valid(val[1]), .timeout(tmo[1]), .level(lvl[1]));

    pwm_capture #(.CNT_W(CW), .MAX_CNT(64), .INVERT(1'b0)) u_thr (
        .clk(clk), .rst(rst_n[2]), .pwm_in(pin[2]), .period(per[2]),
        .high_time(hti[2]), .valid(val[2]), .timeout(tmo[2]), .level(lvl[2]));

    bit inv_c [NI] = '{1'b1, 1'b0, 1'b0};
    int max_c [NI] = '{9600, 9600, 64};

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // model state: expected outputs derived from rise times and sampled levels
    int m_per  [NI];
    int m_ht   [NI];
    bit m_val  [NI];
    bit m_to   [NI];
    bit m_lvl  [NI];
    bit m_meas [NI];
    int m_last [NI];
    int m_act  [NI];
    bit samp   [NI][4];
    bit m_c;
    bit m_pc;
    logic [1:0] ix2;
    logic [1:0] ix3;
    logic [1:0] ix0;

    // valid-strobe log gathered from the DUT
    int vc   [NI] = '{0, 0, 0};
    int lp   [NI];
    int lh   [NI];
    int lvcy [NI];

    task automatic chk(input string nm, input int i, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    // Model: a rise of the sampled pin at edge k acts at edge k+2; period is the
    // edge distance between rises, timeout when MAX_CNT edges pass without one.
    always @(posedge clk) begin
        cyc = cyc + 1;
        ix0 = 2'(cyc);
        ix2 = 2'(cyc - 2);
        ix3 = 2'(cyc - 3);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                m_per[i]  = 0;
                m_ht[i]   = 0;
                m_val[i]  = 1'b0;
                m_to[i]   = 1'b0;
                m_lvl[i]  = 1'b0;
                m_meas[i] = 1'b0;
                m_act[i]  = 0;
                m_last[i] = cyc;
                for (int j = 0; j < 4; j++) samp[i][j] = 1'b0;
            end else begin
                m_c      = samp[i][ix2] ^ inv_c[i];
                m_pc     = samp[i][ix3] ^ inv_c[i];
                m_val[i] = 1'b0;
                if (m_c && !m_pc) begin
                    if (m_meas[i]) begin
                        m_per[i] = cyc - m_last[i];
                        m_ht[i]  = m_act[i];
                        m_val[i] = 1'b1;
                    end
                    m_meas[i] = 1'b1;
                    m_to[i]   = 1'b0;
                    m_last[i] = cyc;
                    m_act[i]  = 1;
                end else begin
                    if (m_c && (m_act[i] < max_c[i])) m_act[i]++;
                    if (!m_to[i] && ((cyc - 1 - m_last[i]) >= (max_c[i] - 1))) begin
                        m_to[i]   = 1'b1;
                        m_lvl[i]  = samp[i][ix2];
                        m_meas[i] = 1'b0;
                    end
                end
                samp[i][ix0] = pin[i];
            end
        end
    end

    // Compare every output of every instance against the model on each negedge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk("period",    i, int'(per[i]), m_per[i]);
            chk("high_time", i, int'(hti[i]), m_ht[i]);
            chk("valid",     i, int'(val[i]), int'(m_val[i]));
            chk("timeout",   i, int'(tmo[i]), int'(m_to[i]));
            chk("level",     i, int'(lvl[i]), int'(m_lvl[i]));
            if (val[i]) begin
                vc[i]++;
                lp[i]   = int'(per[i]);
                lh[i]   = int'(hti[i]);
                lvcy[i] = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_period(input int i, input int p, input int a, output int rc);
        logic act;
        act = ~inv_c[i];
        rc  = 0;
        for (int j = 0; j < p; j++) begin
            @(negedge clk);
            if (j == 0) rc = cyc;
            pin[i] = (j < a) ? act : ~act;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int v;
        int n;

        rst_n = '0;
        pin   = 3'b001;
        idle(3);
        #1;
        chk("reset_period", 0, int'(per[0]), 0);
        chk("reset_valid",  1, int'(val[1]), 0);
        @(negedge clk);
        #2 rst_n = '1;
        idle(5);

        // active-low, period 100, low 30
        for (int k = 0; k < 5; k++) drive_period(0, 100, 30, rc);
        idle(5);
        #1;
        chk("inv_valid_count", 0, vc[0], 4);
        chk("inv_period",      0, lp[0], 100);
        chk("inv_high_time",   0, lh[0], 30);
        chk("inv_latency",     0, lvcy[0] - rc, 3);

        // reset in the middle of a period
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            pin[0] = (j < 30) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("midrst_period",    0, int'(per[0]), 0);
        chk("midrst_high_time", 0, int'(hti[0]), 0);
        chk("midrst_valid",     0, int'(val[0]), 0);
        chk("midrst_timeout",   0, int'(tmo[0]), 0);
        idle(3);
        @(negedge clk);
        #2 rst_n[0] = 1'b1;
        v = vc[0];
        idle(5);
        drive_period(0, 100, 30, rc);
        #1;
        chk("postrst_first_rise_no_valid", 0, vc[0], v);
        drive_period(0, 100, 30, rc);
        drive_period(0, 100, 30, rc);
        idle(5);
        #1;
        chk("postrst_valid_count", 0, vc[0], v + 2);
        chk("postrst_period",      0, lp[0], 100);
        chk("postrst_high_time",   0, lh[0], 30);

        // active-high duty extremes, period 50
        for (int k = 0; k < 4; k++) drive_period(1, 50, 1, rc);
        #1;
        chk("hi1_valid_count", 1, vc[1], 3);
        chk("hi1_period",      1, lp[1], 50);
        chk("hi1_high_time",   1, lh[1], 1);
        for (int k = 0; k < 4; k++) drive_period(1, 50, 49, rc);
        @(negedge clk);
        pin[1] = 1'b1;
        idle(5);
        #1;
        chk("hi49_valid_count", 1, vc[1], 8);
        chk("hi49_period",      1, lp[1], 50);
        chk("hi49_high_time",   1, lh[1], 49);

        // stuck high until timeout
        n = 0;
        while (!tmo[1] && (n < 10000)) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("stuck_timeout",   1, int'(tmo[1]), 1);
        chk("stuck_level",     1, int'(lvl[1]), 1);
        chk("stuck_period",    1, int'(per[1]), 50);
        chk("stuck_high_time", 1, int'(hti[1]), 49);

        // recovery at period 100
        @(negedge clk);
        pin[1] = 1'b0;
        idle(10);
        v = vc[1];
        drive_period(1, 100, 50, rc);
        #1;
        chk("recover_timeout_clear", 1, int'(tmo[1]), 0);
        chk("recover_no_valid",      1, vc[1], v);
        drive_period(1, 100, 50, rc);
        drive_period(1, 100, 50, rc);
        idle(5);
        #1;
        chk("recover_valid_count", 1, vc[1], v + 2);
        chk("recover_period",      1, lp[1], 100);
        chk("recover_high_time",   1, lh[1], 50);

        // rise exactly at the threshold (MAX_CNT = 64)
        v = vc[2];
        for (int k = 0; k < 4; k++) drive_period(2, 64, 32, rc);
        #1;
        chk("thr64_valid_count", 2, vc[2], v + 3);
        chk("thr64_period",      2, lp[2], 64);
        chk("thr64_timeout",     2, int'(tmo[2]), 0);
        for (int k = 0; k < 2; k++) drive_period(2, 65, 32, rc);
        idle(10);
        #1;
        chk("thr65_valid_count", 2, vc[2], v + 4);
        chk("thr65_timeout",     2, int'(tmo[2]), 1);
        chk("thr65_level",       2, int'(lvl[2]), 0);

        idle(5);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
